alarm_buzzer: RTL and testbench

Tone and cadence generator that sits directly downstream of the alarm controller and drives the board buzzer pin. The alarm controller asserts a match level when the current time equals the alarm time. This block turns that level into a gated square wave: a fixed tone frequency, beeped in an on/off cadence. Ringing stops on a button dismiss, a disarm, or after a fixed number of beeps. A new alarm is accepted only after the match level has dropped.

---
 rtl/alarm_buzzer.sv | 134 +++++++++++++
 tb/tb_alarm_buzzer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alarm_buzzer.sv
// Alarm tone/cadence generator: gates a square-wave tone into on/off beeps while
// the alarm matches, stopping on dismiss, disarm or after a fixed beep count.
module alarm_buzzer #(
  parameter int unsigned HALF_PERIOD = 113636,
  parameter int unsigned BEEP_ON     = 50000000,
  parameter int unsigned BEEP_OFF    = 50000000,
  parameter int unsigned NUM_BEEPS   = 60
) (
  input  logic clock,
  input  logic reset,
  input  logic armed,
  input  logic alarm_match,
  input  logic dismiss,
  output logic buzzer,
  output logic ringing
);

  localparam int unsigned PHASE_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int unsigned TONE_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned PHASE_W   = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;
  localparam int unsigned BEEP_W    = (NUM_BEEPS > 1) ? $clog2(NUM_BEEPS) : 1;

  localparam logic [TONE_W-1:0]  TONE_LAST = TONE_W'(HALF_PERIOD - 1);
  localparam logic [PHASE_W-1:0] ON_LAST   = PHASE_W'(BEEP_ON - 1);
  localparam logic [PHASE_W-1:0] OFF_LAST  = PHASE_W'(BEEP_OFF - 1);
  localparam logic [BEEP_W-1:0]  BEEP_LAST = BEEP_W'(NUM_BEEPS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RING_ON  = 2'd1,
    RING_OFF = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e              state_q;
  logic [TONE_W-1:0]   tone_cnt_q;
  logic [PHASE_W-1:0]  phase_cnt_q;
  logic [BEEP_W-1:0]   beep_cnt_q;
  logic                dismiss_q;
  logic                buzzer_q;
  logic                ringing_q;

  logic dismiss_edge;
  logic abort;

  // dismiss_q resets high so a button held through reset is not seen as a press
  assign dismiss_edge = dismiss & ~dismiss_q;
  assign abort        = dismiss_edge | ~armed;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      tone_cnt_q  <= '0;
      phase_cnt_q <= '0;
      beep_cnt_q  <= '0;
      dismiss_q   <= 1'b1;
      buzzer_q    <= 1'b0;
      ringing_q   <= 1'b0;
    end else begin
      dismiss_q <= dismiss;
      case (state_q)
        IDLE: begin
          if (armed && alarm_match) begin
            state_q     <= RING_ON;
            tone_cnt_q  <= '0;
            phase_cnt_q <= '0;
            beep_cnt_q  <= '0;
            buzzer_q    <= 1'b0;
            ringing_q   <= 1'b1;
          end
        end

        RING_ON: begin
          if (abort) begin
            state_q   <= DONE;
            buzzer_q  <= 1'b0;
            ringing_q <= 1'b0;
          end else if (phase_cnt_q == ON_LAST) begin
            // a partial tone period is cut short here
            state_q     <= RING_OFF;
            phase_cnt_q <= '0;
            buzzer_q    <= 1'b0;
          end else begin
            phase_cnt_q <= phase_cnt_q + PHASE_W'(1);
            if (tone_cnt_q == TONE_LAST) begin
              tone_cnt_q <= '0;
              buzzer_q   <= ~buzzer_q;
            end else begin
              tone_cnt_q <= tone_cnt_q + TONE_W'(1);
            end
          end
        end

        RING_OFF: begin
          buzzer_q <= 1'b0;
          if (abort) begin
            state_q   <= DONE;
            ringing_q <= 1'b0;
          end else if (phase_cnt_q == OFF_LAST) begin
            if (beep_cnt_q == BEEP_LAST) begin
              state_q   <= DONE;
              ringing_q <= 1'b0;
            end else begin
              state_q     <= RING_ON;
              beep_cnt_q  <= beep_cnt_q + BEEP_W'(1);
              phase_cnt_q <= '0;
              tone_cnt_q  <= '0;
            end
          end else begin
            phase_cnt_q <= phase_cnt_q + PHASE_W'(1);
          end
        end

        DONE: begin
          // wait for the match level to drop so the same minute cannot re-ring
          buzzer_q <= 1'b0;
          if (!alarm_match) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q   <= IDLE;
          buzzer_q  <= 1'b0;
          ringing_q <= 1'b0;
        end
      endcase
    end
  end

  assign buzzer  = buzzer_q;
  assign ringing = ringing_q;

endmodule

// File: tb/tb_alarm_buzzer.sv
// Directed bench for alarm_buzzer with HALF_PERIOD=2, BEEP_ON=8, BEEP_OFF=4, NUM_BEEPS=3.
module tb_alarm_buzzer;

  logic clock;
  logic reset;
  logic armed;
  logic alarm_match;
  logic dismiss;
  logic buzzer;
  logic ringing;

  int n_checks = 0;
  int n_errors = 0;

  // buzzer level after each edge of one beep+gap, starting with the trigger edge
  int pat [12] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};

  alarm_buzzer #(
    .HALF_PERIOD(2),
    .BEEP_ON    (8),
    .BEEP_OFF   (4),
    .NUM_BEEPS  (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .armed      (armed),
    .alarm_match(alarm_match),
    .dismiss    (dismiss),
    .buzzer     (buzzer),
    .ringing    (ringing)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // advance past one rising edge; inputs are driven and outputs sampled at negedge
  task automatic tick();
    @(negedge clock);
  endtask

  // first tick is the trigger edge; checks ringing and the buzzer pattern per cycle
  task automatic expect_cadence(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      check($sformatf("%s buzzer c%0d", tag, i), 32'(buzzer), 32'(pat[i % 12]));
      check($sformatf("%s ringing c%0d", tag, i), 32'(ringing), 32'd1);
    end
  endtask

  initial begin
    reset       = 1'b0;
    armed       = 1'b0;
    alarm_match = 1'b1;
    dismiss     = 1'b0;

    // reset held with match high but disarmed
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst buzzer c%0d", i), 32'(buzzer), 32'd0);
      check($sformatf("rst ringing c%0d", i), 32'(ringing), 32'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("disarmed ringing c%0d", i), 32'(ringing), 32'd0);
      check($sformatf("disarmed buzzer c%0d", i), 32'(buzzer), 32'd0);
    end

    // full cadence: 3 beeps, 36 ringing cycles, no re-ring while match stays high
    armed = 1'b1;
    expect_cadence("full", 36);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("full no_rering c%0d", i), 32'(ringing), 32'd0);
      check($sformatf("full quiet buzzer c%0d", i), 32'(buzzer), 32'd0);
    end
    alarm_match = 1'b0;
    tick();

    // dismiss during cycle 3 of beep 2
    alarm_match = 1'b1;
    expect_cadence("dis", 15);
    dismiss = 1'b1;
    tick();
    check("dis abort buzzer", 32'(buzzer), 32'd0);
    check("dis abort ringing", 32'(ringing), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("dis held ringing c%0d", i), 32'(ringing), 32'd0);
    end
    dismiss     = 1'b0;
    alarm_match = 1'b0;
    tick();

    // disarm during RING_OFF, re-arm while matching, then a fresh match
    alarm_match = 1'b1;
    expect_cadence("pre_disarm", 10);
    armed = 1'b0;
    tick();
    check("disarm ringing", 32'(ringing), 32'd0);
    check("disarm buzzer", 32'(buzzer), 32'd0);
    armed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rearm no_ring c%0d", i), 32'(ringing), 32'd0);
    end
    alarm_match = 1'b0;
    tick();
    check("rematch low ringing", 32'(ringing), 32'd0);
    alarm_match = 1'b1;
    expect_cadence("restart", 36);
    tick();
    check("restart timeout ringing", 32'(ringing), 32'd0);
    alarm_match = 1'b0;
    tick();

    // reset mid-tone while buzzer is high
    alarm_match = 1'b1;
    expect_cadence("pre_rst", 3);
    check("pre_rst buzzer high", 32'(buzzer), 32'd1);
    reset = 1'b0;
    tick();
    check("midrst buzzer", 32'(buzzer), 32'd0);
    check("midrst ringing", 32'(ringing), 32'd0);
    reset = 1'b1;
    expect_cadence("post_rst", 36);
    tick();
    check("post_rst timeout ringing", 32'(ringing), 32'd0);
    alarm_match = 1'b0;
    tick();

    // dismiss held through reset is not a press
    dismiss = 1'b1;
    reset   = 1'b0;
    tick();
    tick();
    check("held_rst ringing", 32'(ringing), 32'd0);
    reset       = 1'b1;
    alarm_match = 1'b1;
    expect_cadence("held", 36);
    tick();
    check("held timeout ringing", 32'(ringing), 32'd0);
    alarm_match = 1'b0;
    tick();
    dismiss     = 1'b0;
    alarm_match = 1'b1;
    expect_cadence("fresh", 6);
    dismiss = 1'b1;
    tick();
    check("fresh abort ringing", 32'(ringing), 32'd0);
    check("fresh abort buzzer", 32'(buzzer), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
